// File: rtl/sd_clock_monitor_if.sv
// Signal bundle between the SD host core and sd_clock_monitor.
// master drives enable/divider/SD clock, slave (the monitor) returns status.
interface sd_clock_monitor_if;
    logic       EN;
    logic [7:0] DIVIDER;
    logic       SD_CLK;
    logic       RISE;
    logic       FALL;
    logic [7:0] MEAS_DIV;
    logic       MEAS_VALID;
    logic       LOCKED;
    logic       MISMATCH;
    logic       STALL;

    modport master (
        output EN, DIVIDER, SD_CLK,
        input  RISE, FALL, MEAS_DIV, MEAS_VALID, LOCKED, MISMATCH, STALL
    );

    modport slave (
        input  EN, DIVIDER, SD_CLK,
        output RISE, FALL, MEAS_DIV, MEAS_VALID, LOCKED, MISMATCH, STALL
    );
endinterface

// File: rtl/sd_clock_monitor.sv
// Measures SD_CLK half-periods against DIVIDER, reporting lock, mismatch and stall.
// Define SD_CLK_MON_SYNC_EN to pass SD_CLK through a 2-flop synchronizer first.
module sd_clock_monitor #(
    parameter int unsigned LOCK_CNT = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    sd_clock_monitor_if.slave mon
);
    localparam logic [3:0] LOCK_CNT_W = 4'(LOCK_CNT);
    localparam logic [8:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACQUIRE,
        S_MEASURE,
        S_LOCKED
    } state_t;

    state_t     state_q, state_d;
    logic       sd_s;
    logic       sd_q;
    logic [8:0] cnt_q, cnt_d;
    logic [3:0] match_q, match_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;
    logic [7:0] meas_div_q, meas_div_d;
    logic       meas_valid_q, meas_valid_d;
    logic       locked_q, locked_d;
    logic       mismatch_q, mismatch_d;
    logic       stall_q, stall_d;

    logic       edge_w;
    logic       match_w;
    logic       lock_hit_w;
    logic       stall_w;
    logic [8:0] cnt_inc_w;

`ifdef SD_CLK_MON_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], mon.SD_CLK};
        end
    end

    assign sd_s = sync_q[1];
`else
    assign sd_s = mon.SD_CLK;
`endif

    assign edge_w     = (sd_s != sd_q);
    assign match_w    = (cnt_q == {1'b0, mon.DIVIDER});
    assign lock_hit_w = ((match_q + 4'd1) == LOCK_CNT_W);
    assign cnt_inc_w  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 9'd1;
    // An edge coinciding with saturation wins; only an edgeless cycle can stall.
    assign stall_w    = !edge_w && (cnt_inc_w == CNT_MAX);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!mon.EN) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    state_d = S_ACQUIRE;
                S_ACQUIRE: if (edge_w) state_d = S_MEASURE;
                S_MEASURE: begin
                    if (edge_w) begin
                        if (match_w && lock_hit_w) state_d = S_LOCKED;
                    end else if (stall_w) begin
                        state_d = S_ACQUIRE;
                    end
                end
                S_LOCKED: begin
                    if (edge_w) begin
                        if (!match_w) state_d = S_MEASURE;
                    end else if (stall_w) begin
                        state_d = S_ACQUIRE;
                    end
                end
                default:   state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d        = cnt_q;
        match_d      = match_q;
        rise_d       = 1'b0;
        fall_d       = 1'b0;
        meas_div_d   = meas_div_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
        mismatch_d   = 1'b0;
        stall_d      = stall_q;

        if (!mon.EN || state_q == S_IDLE) begin
            cnt_d      = '0;
            match_d    = '0;
            meas_div_d = '0;
            locked_d   = 1'b0;
            stall_d    = 1'b0;
        end else begin
            cnt_d  = edge_w ? '0 : cnt_inc_w;
            rise_d = edge_w && sd_s;
            fall_d = edge_w && !sd_s;
            if (edge_w) stall_d = 1'b0;

            case (state_q)
                S_ACQUIRE: begin
                    if (stall_w) stall_d = 1'b1;
                end
                S_MEASURE: begin
                    if (edge_w) begin
                        meas_div_d   = cnt_q[7:0];
                        meas_valid_d = 1'b1;
                        if (match_w) begin
                            if (lock_hit_w) begin
                                match_d  = '0;
                                locked_d = 1'b1;
                            end else begin
                                match_d  = match_q + 4'd1;
                            end
                        end else begin
                            match_d = '0;
                        end
                    end else if (stall_w) begin
                        stall_d  = 1'b1;
                        locked_d = 1'b0;
                        match_d  = '0;
                    end
                end
                S_LOCKED: begin
                    if (edge_w) begin
                        meas_div_d   = cnt_q[7:0];
                        meas_valid_d = 1'b1;
                        if (!match_w) begin
                            mismatch_d = 1'b1;
                            locked_d   = 1'b0;
                            match_d    = '0;
                        end
                    end else if (stall_w) begin
                        stall_d  = 1'b1;
                        locked_d = 1'b0;
                        match_d  = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sd_q         <= 1'b0;
            cnt_q        <= '0;
            match_q      <= '0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            meas_div_q   <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            mismatch_q   <= 1'b0;
            stall_q      <= 1'b0;
        end else begin
            sd_q         <= sd_s;
            cnt_q        <= cnt_d;
            match_q      <= match_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            meas_div_q   <= meas_div_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            mismatch_q   <= mismatch_d;
            stall_q      <= stall_d;
        end
    end

    assign mon.RISE       = rise_q;
    assign mon.FALL       = fall_q;
    assign mon.MEAS_DIV   = meas_div_q;
    assign mon.MEAS_VALID = meas_valid_q;
    assign mon.LOCKED     = locked_q;
    assign mon.MISMATCH   = mismatch_q;
    assign mon.STALL      = stall_q;
endmodule
